// File: rtl/rsa_byte_stream_loader.sv
// Byte-stream loader/unloader for the 256-bit RSA core: shifts in N, D, A
// MSB-first over rx, pulses the core start, then streams the result out on tx.
// Ports: i_clk/i_rst (sync active-high), rx byte stream (i_rx_data,
// i_rx_valid, o_rx_ready), i_rekey, tx byte stream (o_tx_data, o_tx_valid,
// i_tx_ready), core side (o_core_start, o_core_a/d/n, i_core_a_pow_d,
// i_core_finished), o_busy.
// Option: RSA_STREAM_OUT_32B_EN sends all 32 result bytes (default 31).
module rsa_byte_stream_loader #(
  parameter int N_BYTES = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_rx_ready,
  input  logic                 i_rekey,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_core_start,
  output logic [8*N_BYTES-1:0] o_core_a,
  output logic [8*N_BYTES-1:0] o_core_d,
  output logic [8*N_BYTES-1:0] o_core_n,
  input  logic [8*N_BYTES-1:0] i_core_a_pow_d,
  input  logic                 i_core_finished,
  output logic                 o_busy
);

  localparam int W  = 8 * N_BYTES;
  localparam int CW = $clog2(N_BYTES);

  localparam logic [CW-1:0] RX_LAST = CW'(N_BYTES - 1);
`ifdef RSA_STREAM_OUT_32B_EN
  localparam logic [CW-1:0] TX_LAST = CW'(N_BYTES - 1);
`else
  localparam logic [CW-1:0] TX_LAST = CW'(N_BYTES - 2);
`endif

  localparam logic [2:0] S_LOAD_N = 3'd0;
  localparam logic [2:0] S_LOAD_D = 3'd1;
  localparam logic [2:0] S_LOAD_A = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_SEND   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  n_q, n_d;
  logic [W-1:0]  d_q, d_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  res_q, res_d;

  logic rx_fire;
  logic tx_fire;
  logic in_load;

  assign in_load = (state_q == S_LOAD_N) ||
                   (state_q == S_LOAD_D) ||
                   (state_q == S_LOAD_A);

  // Rekey must win over a coincident byte, so refuse it while rekey is up.
  assign o_rx_ready = in_load &&
                      !((state_q == S_LOAD_A) && i_rekey);

  assign o_tx_valid   = (state_q == S_SEND);
  assign o_tx_data    = o_tx_valid ? res_q[W-1 -: 8] : 8'h00;
  assign o_core_start = (state_q == S_START);
  assign o_busy       = (state_q == S_START) ||
                        (state_q == S_WAIT) ||
                        (state_q == S_SEND);

  assign o_core_a = a_q;
  assign o_core_d = d_q;
  assign o_core_n = n_q;

  assign rx_fire = i_rx_valid && o_rx_ready;
  assign tx_fire = o_tx_valid && i_tx_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    d_d     = d_q;
    a_d     = a_q;
    res_d   = res_q;
    unique case (state_q)
      S_LOAD_N: begin
        if (rx_fire) begin
          n_d   = {n_q[W-9:0], i_rx_data};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == RX_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD_D;
          end
        end
      end
      S_LOAD_D: begin
        if (rx_fire) begin
          d_d   = {d_q[W-9:0], i_rx_data};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == RX_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD_A;
          end
        end
      end
      S_LOAD_A: begin
        if (i_rekey && (cnt_q == '0)) begin
          state_d = S_LOAD_N;
        end else if (rx_fire) begin
          a_d   = {a_q[W-9:0], i_rx_data};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == RX_LAST) begin
            cnt_d   = '0;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_core_finished) begin
          // Result is pre-aligned so the first byte out sits at the top.
`ifdef RSA_STREAM_OUT_32B_EN
          res_d = i_core_a_pow_d;
`else
          res_d = {i_core_a_pow_d[W-9:0], 8'h00};
`endif
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_fire) begin
          res_d = {res_q[W-9:0], 8'h00};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == TX_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD_A;
          end
        end
      end
      default: begin
        state_d = S_LOAD_N;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_LOAD_N;
      cnt_q   <= '0;
      n_q     <= '0;
      d_q     <= '0;
      a_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      d_q     <= d_d;
      a_q     <= a_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_rsa_byte_stream_loader.sv
// Directed bench for rsa_byte_stream_loader with a small behavioural
// modexp core model and hand-computed expected results.
module tb_rsa_byte_stream_loader;

`ifdef RSA_STREAM_OUT_32B_EN
  localparam int NB = 32;
`else
  localparam int NB = 31;
`endif

  logic         clk = 0;
  logic         rst = 1;
  logic [7:0]   rx_data = 0;
  logic         rx_valid = 0;
  logic         rx_ready;
  logic         rekey = 0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 0;
  logic         core_start;
  logic [255:0] core_a, core_d, core_n;
  logic [255:0] core_res = 0;
  logic         core_fin = 0;
  logic         busy;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  bit core_auto = 1;

  always #5 clk = ~clk;

  rsa_byte_stream_loader dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready),
    .i_rekey(rekey),
    .o_tx_data(tx_data),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready),
    .o_core_start(core_start),
    .o_core_a(core_a),
    .o_core_d(core_d),
    .o_core_n(core_n),
    .i_core_a_pow_d(core_res),
    .i_core_finished(core_fin),
    .o_busy(busy)
  );

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint modexp(input longint b,
                                    input longint e,
                                    input longint m);
    longint r, x, k;
    r = 1;
    x = b % m;
    k = e;
    while (k > 0) begin
      if (k[0]) r = (r * x) % m;
      x = (x * x) % m;
      k = k >> 1;
    end
    return r;
  endfunction

  // Behavioural core: answers a few cycles after each start pulse.
  always begin
    @(negedge clk);
    if (core_start) begin
      start_cnt++;
      if (core_auto) begin
        repeat (3) @(negedge clk);
        core_res = 256'(modexp(longint'(core_a[15:0]),
                                longint'(core_d[15:0]),
                                longint'(core_n[15:0])));
        core_fin = 1;
        @(negedge clk);
        core_fin = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer.
  task automatic push(input logic [7:0] b);
    int t;
    rx_data  = b;
    rx_valid = 1;
    t = 0;
    #1;
    while (!rx_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 200) chk("push_timeout", 1, 0);
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic push_op(input logic [7:0] lsb);
    for (int i = 0; i < 31; i++) push(8'h00);
    push(lsb);
  endtask

  task automatic recv(input bit stall, input logic [7:0] last);
    int t, k, n;
    logic [7:0] held;
    n = 0;
    for (int i = 0; i < NB; i++) begin
      tx_ready = !stall;
      t = 0;
      #1;
      while (!tx_valid && t < 200) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (t >= 200) begin
        chk("tx_timeout", 1, 0);
        break;
      end
      if (stall) begin
        held = tx_data;
        k = $urandom_range(0, 5);
        repeat (k) begin
          @(negedge clk);
          #1;
          chk("tx_hold_data", tx_data, held);
          chk("tx_hold_valid", tx_valid, 1);
        end
        tx_ready = 1;
      end
      chk($sformatf("tx_byte%0d", i), tx_data,
          (i == NB - 1) ? last : 8'h00);
      n++;
      @(negedge clk);
    end
    tx_ready = 0;
    chk("tx_count", n, NB);
    #1;
    chk("tx_valid_drop", tx_valid, 0);
    chk("busy_drop", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", core_start, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_a", core_a, 0);
    chk("rst_d", core_d, 0);
    chk("rst_n", core_n, 0);

    // First message: 5^20 mod 221 = 183.
    @(negedge clk);
    push_op(8'hDD);
    push_op(8'h14);
    push_op(8'h05);
    #1;
    chk("m1_start", core_start, 1);
    chk("m1_busy", busy, 1);
    chk("m1_n", core_n, 256'd221);
    chk("m1_d", core_d, 256'd20);
    chk("m1_a", core_a, 256'd5);
    @(negedge clk);
    #1;
    chk("m1_start_one", core_start, 0);
    recv(0, 8'hB7);
    chk("m1_starts", start_cnt, 1);

    // Second message, key kept: 2^20 mod 221 = 152.
    push_op(8'h02);
    rx_valid = 1;
    rx_data  = 8'hFF;
    @(negedge clk);
    #1;
    chk("m2_rx_ready_busy", rx_ready, 0);
    chk("m2_n_kept", core_n, 256'd221);
    chk("m2_d_kept", core_d, 256'd20);
    chk("m2_a", core_a, 256'd2);
    recv(1, 8'h98);
    rx_valid = 0;
    chk("m2_a_unchanged", core_a, 256'd2);
    chk("m2_n_unchanged", core_n, 256'd221);
    chk("m2_starts", start_cnt, 2);

    // Rekey coincident with first A byte.
    rekey    = 1;
    rx_valid = 1;
    rx_data  = 8'h77;
    #1;
    chk("rk_refused", rx_ready, 0);
    @(negedge clk);
    rekey    = 0;
    rx_valid = 0;
    #1;
    chk("rk_a_unchanged", core_a, 256'd2);
    chk("rk_ready_loadn", rx_ready, 1);
    @(negedge clk);
    // 5^20 mod 187 = 166.
    push_op(8'hBB);
    push_op(8'h14);
    push_op(8'h05);
    #1;
    chk("rk_n", core_n, 256'd187);
    chk("rk_d", core_d, 256'd20);
    chk("rk_a", core_a, 256'd5);
    recv(0, 8'hA6);
    chk("rk_starts", start_cnt, 3);

    // Reset while waiting on the core.
    core_auto = 0;
    push_op(8'h03);
    @(negedge clk);
    #1;
    chk("rw_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    core_res = 256'hB7;
    core_fin = 1;
    @(negedge clk);
    core_fin = 0;
    tx_ready = 1;
    repeat (3) begin
      #1;
      chk("rw_tx_valid", tx_valid, 0);
      @(negedge clk);
    end
    #1;
    chk("rw_rx_ready", rx_ready, 1);
    chk("rw_busy_low", busy, 0);
    chk("rw_a", core_a, 0);
    chk("rw_d", core_d, 0);
    chk("rw_n", core_n, 0);
    tx_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
